quarter_round_inv: RTL and testbench

Iterative inverse ChaCha20 quarter-round engine. It takes a post-quarter-round word quadruple (a, b, c, d) and recovers the pre-round quadruple by undoing the four add/xor/rotate half-steps in reverse order, one per clock. It is the decode-direction counterpart of the combinational forward half-step. It is used for round-trip verification of the forward datapath and for state rewind in the cipher core.

---
 rtl/chacha_pkg.sv | 21 ++
 rtl/quarter_round_inv_step.sv | 17 +
 rtl/quarter_round_inv.sv | 112 +++++++++++
 tb/tb_quarter_round_inv.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types and constants for the quarter-round engines.
package chacha_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int QR_STEPS = 4;

   // Rotate amounts in the order the inverse steps consume them.
   localparam logic [4:0] ROT_INV [QR_STEPS] = '{5'd7, 5'd8, 5'd12, 5'd16};

   function automatic word_t rotr(input word_t x, input logic [4:0] n);
      return (x >> n) | (x << (6'd32 - {1'b0, n}));
   endfunction

endpackage

// File: rtl/quarter_round_inv_step.sv
// One inverse half-step: undo a rotate/xor and an add on the selected words.
module quarter_round_inv_step
   import chacha_pkg::*;
(
   input  word_t      x,
   input  word_t      y,
   input  word_t      z,
   input  word_t      w,
   input  logic [1:0] sel,
   output word_t      x_new,
   output word_t      z_new
);

   assign x_new = rotr(x, ROT_INV[sel]) ^ y;
   assign z_new = z - w;

endmodule

// File: rtl/quarter_round_inv.sv
// Iterative inverse ChaCha20 quarter round: recovers the pre-round words in four cycles.
module quarter_round_inv
   import chacha_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  word_t in_a,
   input  word_t in_b,
   input  word_t in_c,
   input  word_t in_d,
   output logic  out_valid,
   input  logic  out_ready,
   output word_t out_a,
   output word_t out_b,
   output word_t out_c,
   output word_t out_d
);

   localparam logic [1:0] LAST_STEP = 2'(QR_STEPS - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] step;
   word_t      work_a, work_b, work_c, work_d;
   word_t      x, y, z, w, x_new, z_new;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (step == LAST_STEP) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Even steps undo the b/c half of the round, odd steps the d/a half.
   always_comb begin
      if (!step[0]) begin
         x = work_b;
         y = work_c;
         z = work_c;
         w = work_d;
      end else begin
         x = work_d;
         y = work_a;
         z = work_a;
         w = work_b;
      end
   end

   quarter_round_inv_step u_step (
      .x     (x),
      .y     (y),
      .z     (z),
      .w     (w),
      .sel   (step),
      .x_new (x_new),
      .z_new (z_new)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step   <= '0;
         work_a <= '0;
         work_b <= '0;
         work_c <= '0;
         work_d <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  step   <= '0;
                  work_a <= in_a;
                  work_b <= in_b;
                  work_c <= in_c;
                  work_d <= in_d;
               end
            end
            RUN: begin
               step <= step + 2'd1;
               if (!step[0]) begin
                  work_b <= x_new;
                  work_c <= z_new;
               end else begin
                  work_d <= x_new;
                  work_a <= z_new;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_a = work_a;
   assign out_b = work_b;
   assign out_c = work_c;
   assign out_d = work_d;

endmodule

// File: tb/tb_quarter_round_inv.sv
// Scoreboard bench for quarter_round_inv using a software forward/inverse quarter round.
module tb_quarter_round_inv;

   typedef logic [127:0] quad_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_a, out_b, out_c, out_d;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   quad_t sb[$];

   quarter_round_inv dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_c      (in_c),
      .in_d      (in_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_d     (out_d)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [31:0] rotr32(input logic [31:0] v, input int n);
      return (v >> n) | (v << (32 - n));
   endfunction

   function automatic quad_t qr_fwd(input quad_t q);
      logic [31:0] a, b, c, d;
      {a, b, c, d} = q;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic quad_t qr_inv(input quad_t q);
      logic [31:0] a, b, c, d;
      {a, b, c, d} = q;
      b = rotr32(b, 7) ^ c;  c = c - d;
      d = rotr32(d, 8) ^ a;  a = a - b;
      b = rotr32(b, 12) ^ c; c = c - d;
      d = rotr32(d, 16) ^ a; a = a - b;
      return {a, b, c, d};
   endfunction

   task automatic checkOutput(input string tag, input quad_t obs, input quad_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input quad_t post, input quad_t exp);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("in_ready_before_accept", quad_t'(in_ready), quad_t'(1));
      in_valid = 1'b1;
      {in_a, in_b, in_c, in_d} = post;
      sb.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic awaitResult(input string tag);
      int    lat = 0;
      logic  saw_ready = 1'b0;
      quad_t exp = '0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (in_ready) saw_ready = 1'b1;
      end
      checkOutput({tag, "_latency"}, quad_t'(lat), quad_t'(4));
      checkOutput({tag, "_in_ready_busy"}, quad_t'(saw_ready), quad_t'(0));
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 'x;
      checkOutput({tag, "_data"}, {out_a, out_b, out_c, out_d}, exp);
   endtask

   localparam quad_t RFC_POST = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
   localparam quad_t RFC_PRE  = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};

   initial begin
      quad_t held;
      quad_t pre;
      quad_t exp;
      int    n;
      int    last_cyc;

      // Reset state
      #12;
      checkOutput("reset_state", {out_valid, in_ready, out_a, out_b, out_c, out_d},
                  {1'b0, 1'b1, 128'h0});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RFC 7539 vector and all-zero vector
      applyStimulus(RFC_POST, RFC_PRE);
      awaitResult("rfc");
      @(posedge clk); #1;
      applyStimulus('0, '0);
      awaitResult("zero");
      @(posedge clk); #1;

      // Backpressure with noisy inputs while in DONE
      out_ready = 1'b0;
      applyStimulus(RFC_POST, RFC_PRE);
      awaitResult("bp");
      held = {out_a, out_b, out_c, out_d};
      for (int i = 0; i < 10; i++) begin
         in_valid = ~in_valid;
         {in_a, in_b, in_c, in_d} = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         checkOutput("bp_hold_data", {out_a, out_b, out_c, out_d}, RFC_PRE);
         checkOutput("bp_hold_flags", quad_t'({out_valid, in_ready}), quad_t'(2'b10));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_release_ready", quad_t'({out_valid, in_ready}), quad_t'(2'b01));
      applyStimulus(RFC_POST ^ 128'h1, qr_inv(RFC_POST ^ 128'h1));
      awaitResult("post_bp");
      @(posedge clk); #1;

      // Reset in the middle of RUN discards the quadruple
      applyStimulus(RFC_POST, RFC_PRE);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrun_reset", {out_valid, in_ready, out_a, out_b, out_c, out_d},
                  {1'b0, 1'b1, 128'h0});
      if (sb.size() > 0) void'(sb.pop_front());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(RFC_POST, RFC_PRE);
      awaitResult("after_reset");
      @(posedge clk); #1;

      // Wrap-around subtraction
      exp = qr_inv({32'h00000000, 32'hffffffff, 32'h00000000, 32'hffffffff});
      applyStimulus({32'h00000000, 32'hffffffff, 32'h00000000, 32'hffffffff}, exp);
      awaitResult("wrap");
      @(posedge clk); #1;

      // Back-to-back random round trips, in_valid and out_ready held high
      out_ready = 1'b1;
      in_valid  = 1'b1;
      last_cyc  = 0;
      for (int i = 0; i < 100; i++) begin
         pre = {$urandom, $urandom, $urandom, $urandom};
         {in_a, in_b, in_c, in_d} = qr_fwd(pre);
         sb.push_back(pre);
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!out_valid && n < 20);
         if (sb.size() > 0) exp = sb.pop_front();
         else exp = 'x;
         checkOutput("b2b_data", {out_a, out_b, out_c, out_d}, exp);
         if (i > 0) checkOutput("b2b_period", quad_t'(cyc - last_cyc), quad_t'(6));
         last_cyc = cyc;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("final_idle", quad_t'({out_valid, in_ready}), quad_t'(2'b01));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
